// File: rtl/zcu_timer_pkg.sv
// Shared types and elaboration helpers for the multi-channel millisecond stopwatch.
package zcu_timer_pkg;

    typedef enum logic [1:0] {TMR_IDLE, TMR_RUN, TMR_HOLD} tmr_state_t;

    function automatic int pre_max(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz - 1;
    endfunction

    // A prescaler that never counts still needs a one-bit register.
    function automatic int pre_width(input int pmax);
        return (pmax > 0) ? $clog2(pmax + 1) : 1;
    endfunction

endpackage

// File: rtl/zcu_timer_channel.sv
// One stopwatch channel: start-toggle synchroniser, IDLE/RUN/HOLD control,
// prescaler, elapsed counter with overflow handling, and lap capture register.
module zcu_timer_channel
    import zcu_timer_pkg::*;
#(
    parameter int PRE_MAX  = 9,
    parameter int WIDTH    = 24,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             lap,
    output logic [WIDTH-1:0] elapsed,
    output logic [WIDTH-1:0] lap_time,
    output logic             lap_valid,
    output logic             running,
    output logic             overflow
);

    localparam int               PRE_W   = pre_width(PRE_MAX);
    localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(PRE_MAX);
    localparam logic [WIDTH-1:0] EL_ONES = {WIDTH{1'b1}};

    // Returns {overflow, next elapsed} for one tick increment.
    function automatic logic [WIDTH:0] tick_inc(input logic [WIDTH-1:0] v);
        if (v == EL_ONES) begin
            return SATURATE ? {1'b1, EL_ONES} : {1'b1, {WIDTH{1'b0}}};
        end
        return {1'b0, v + 1'b1};
    endfunction

    logic             start_p0, start_p1, start_p2;
    logic             start_edge;
    tmr_state_t       state, state_nxt;
    logic [PRE_W-1:0] pre_cnt, pre_nxt;
    logic [WIDTH-1:0] el_cnt, el_nxt;
    logic [WIDTH-1:0] lap_reg, lap_nxt;
    logic             ovf_reg, ovf_nxt;
    logic             lap_vld_p1, lap_vld_nxt;
    logic [WIDTH:0]   el_inc;

    // Stage p0/p1: metastability filter; p2: previous value for toggle detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_p0 <= 1'b0;
            start_p1 <= 1'b0;
            start_p2 <= 1'b0;
        end else begin
            start_p0 <= start;
            start_p1 <= start_p0;
            start_p2 <= start_p1;
        end
    end

    assign start_edge = start_p1 ^ start_p2;
    assign el_inc     = tick_inc(el_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= TMR_IDLE;
            pre_cnt    <= '0;
            el_cnt     <= '0;
            lap_reg    <= '0;
            ovf_reg    <= 1'b0;
            lap_vld_p1 <= 1'b0;
        end else begin
            state      <= state_nxt;
            pre_cnt    <= pre_nxt;
            el_cnt     <= el_nxt;
            lap_reg    <= lap_nxt;
            ovf_reg    <= ovf_nxt;
            lap_vld_p1 <= lap_vld_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pre_nxt     = pre_cnt;
        el_nxt      = el_cnt;
        ovf_nxt     = ovf_reg;
        lap_nxt     = lap_reg;
        lap_vld_nxt = 1'b0;
        if (clear) begin
            state_nxt = TMR_IDLE;
            pre_nxt   = '0;
            el_nxt    = '0;
            ovf_nxt   = 1'b0;
            lap_nxt   = '0;
        end else begin
            // Lap sees the registered count, so a same-cycle tick is not included.
            if (lap && (state != TMR_IDLE)) begin
                lap_nxt     = el_cnt;
                lap_vld_nxt = 1'b1;
            end
            case (state)
                TMR_IDLE: begin
                    if (start_edge) begin
                        state_nxt = TMR_RUN;
                        pre_nxt   = '0;
                        el_nxt    = '0;
                        ovf_nxt   = 1'b0;
                    end
                end
                TMR_RUN: begin
                    if (stop) begin
                        state_nxt = TMR_HOLD;
                    end else if (pre_cnt == PRE_TOP) begin
                        pre_nxt = '0;
                        el_nxt  = el_inc[WIDTH-1:0];
                        if (el_inc[WIDTH]) begin
                            ovf_nxt = 1'b1;
                        end
                    end else begin
                        pre_nxt = pre_cnt + 1'b1;
                    end
                end
                TMR_HOLD: begin
                    if (start_edge) begin
                        state_nxt = TMR_RUN;
                    end
                end
                default: state_nxt = TMR_IDLE;
            endcase
        end
    end

    assign elapsed   = el_cnt;
    assign lap_time  = lap_reg;
    assign lap_valid = lap_vld_p1;
    assign running   = (state == TMR_RUN);
    assign overflow  = ovf_reg;

endmodule

// File: rtl/zcu_multi_timer.sv
// N independent stopwatch channels sharing one clock; outputs are packed
// with channel i at [i*WIDTH +: WIDTH].
module zcu_multi_timer
    import zcu_timer_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int N_CH     = 4,
    parameter int WIDTH    = 24,
    parameter bit SATURATE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       clear,
    input  logic [N_CH-1:0]       start,
    input  logic [N_CH-1:0]       stop,
    input  logic [N_CH-1:0]       lap,
    output logic [N_CH*WIDTH-1:0] elapsed,
    output logic [N_CH*WIDTH-1:0] lap_time,
    output logic [N_CH-1:0]       lap_valid,
    output logic [N_CH-1:0]       running,
    output logic [N_CH-1:0]       overflow
);

    localparam int PRE_MAX = pre_max(CLK_HZ, TICK_HZ);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        zcu_timer_channel #(
            .PRE_MAX  (PRE_MAX),
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .clear     (clear[i]),
            .start     (start[i]),
            .stop      (stop[i]),
            .lap       (lap[i]),
            .elapsed   (elapsed[i*WIDTH +: WIDTH]),
            .lap_time  (lap_time[i*WIDTH +: WIDTH]),
            .lap_valid (lap_valid[i]),
            .running   (running[i]),
            .overflow  (overflow[i])
        );
    end

endmodule

// File: tb/tb_zcu_multi_timer.sv
// Bench for zcu_multi_timer: reference model tracks clocks spent running per
// channel; three DUT views (8-bit saturating, 4-bit saturating, 4-bit wrapping).
module tb_zcu_multi_timer;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int SW    = 4;
    localparam int TICKS = 10;

    logic clk, rst;
    logic [N-1:0] clear, start, stop, lap;

    logic [N*W-1:0] el_m, lt_m;
    logic [N-1:0]   lv_m, run_m, ov_m;
    logic [2*SW-1:0] el_s, lt_s, el_w, lt_w;
    logic [1:0]      lv_s, run_s, ov_s, lv_w, run_w, ov_w;

    zcu_multi_timer #(.CLK_HZ(1000), .TICK_HZ(100), .N_CH(N), .WIDTH(W), .SATURATE(1'b1)) dut (
        .clk(clk), .rst(rst), .clear(clear), .start(start), .stop(stop), .lap(lap),
        .elapsed(el_m), .lap_time(lt_m), .lap_valid(lv_m), .running(run_m), .overflow(ov_m));

    zcu_multi_timer #(.CLK_HZ(1000), .TICK_HZ(100), .N_CH(2), .WIDTH(SW), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .clear(clear[1:0]), .start(start[1:0]), .stop(stop[1:0]), .lap(lap[1:0]),
        .elapsed(el_s), .lap_time(lt_s), .lap_valid(lv_s), .running(run_s), .overflow(ov_s));

    zcu_multi_timer #(.CLK_HZ(1000), .TICK_HZ(100), .N_CH(2), .WIDTH(SW), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .clear(clear[1:0]), .start(start[1:0]), .stop(stop[1:0]), .lap(lap[1:0]),
        .elapsed(el_w), .lap_time(lt_w), .lap_valid(lv_w), .running(run_w), .overflow(ov_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs  = 0;
    int fails = 0;

    // Reference model: mode 0 idle, 1 run, 2 hold; run_clk counts counting clocks.
    int     mode    [N];
    longint run_clk [N];
    longint lap_tk  [N];
    bit     lapv    [N];
    bit     st_last [N];
    longint due     [N];
    longint cyc = 0;
    longint lapq [N][$];

    function automatic longint vel(longint t, int w, bit sat);
        longint mx = (longint'(1) << w) - 1;
        if (t <= mx) return t;
        return sat ? mx : (t % (mx + 1));
    endfunction

    function automatic longint vovf(longint t, int w);
        return (t > ((longint'(1) << w) - 1)) ? 1 : 0;
    endfunction

    task automatic cmp(input string name, input int ch, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s ch%0d: got %0d, expected %0d (t=%0t)", name, ch, act, exp, $time);
        end
    endtask

    task automatic model_step();
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                mode[i] = 0; run_clk[i] = 0; lap_tk[i] = 0; lapv[i] = 0;
                st_last[i] = 0; due[i] = -1;
            end else begin
                bit act;
                act = (due[i] == cyc);
                if (act) due[i] = -1;
                if (start[i] != st_last[i]) begin
                    st_last[i] = start[i];
                    due[i] = cyc + 2;
                end
                lapv[i] = 0;
                if (clear[i]) begin
                    mode[i] = 0; run_clk[i] = 0; lap_tk[i] = 0;
                end else begin
                    if (lap[i] && mode[i] != 0) begin
                        lap_tk[i] = run_clk[i] / TICKS;
                        lapv[i] = 1;
                        lapq[i].push_back(lap_tk[i]);
                    end
                    case (mode[i])
                        0: if (act) begin mode[i] = 1; run_clk[i] = 0; end
                        1: if (stop[i]) mode[i] = 2; else run_clk[i]++;
                        default: if (act) mode[i] = 1;
                    endcase
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: continuous comparison plus lap scoreboard popped on lap_valid.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            longint t;
            t = run_clk[i] / TICKS;
            cmp("elapsed_m", i, 64'(el_m[i*W +: W]), 64'(vel(t, W, 1)));
            cmp("overflow_m", i, 64'(ov_m[i]), 64'(vovf(t, W)));
            cmp("running_m", i, 64'(run_m[i]), 64'(mode[i] == 1));
            cmp("lap_valid_m", i, 64'(lv_m[i]), 64'(lapv[i]));
            cmp("lap_time_m", i, 64'(lt_m[i*W +: W]), 64'(vel(lap_tk[i], W, 1)));
            if (i < 2) begin
                cmp("elapsed_s", i, 64'(el_s[i*SW +: SW]), 64'(vel(t, SW, 1)));
                cmp("overflow_s", i, 64'(ov_s[i]), 64'(vovf(t, SW)));
                cmp("elapsed_w", i, 64'(el_w[i*SW +: SW]), 64'(vel(t, SW, 0)));
                cmp("overflow_w", i, 64'(ov_w[i]), 64'(vovf(t, SW)));
                cmp("running_w", i, 64'(run_w[i]), 64'(mode[i] == 1));
                cmp("lap_valid_s", i, 64'(lv_s[i]), 64'(lapv[i]));
            end
            if (lv_m[i]) begin
                if (lapq[i].size() == 0) begin
                    cmp("lap_unexpected", i, 64'(1), 64'(0));
                end else begin
                    longint e;
                    e = lapq[i].pop_front();
                    cmp("lap_pop_m", i, 64'(lt_m[i*W +: W]), 64'(vel(e, W, 1)));
                    if (i < 2) begin
                        cmp("lap_pop_s", i, 64'(lt_s[i*SW +: SW]), 64'(vel(e, SW, 1)));
                        cmp("lap_pop_w", i, 64'(lt_w[i*SW +: SW]), 64'(vel(e, SW, 0)));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic toggle(input int ch);
        start[ch] = ~start[ch];
    endtask

    task automatic wait_run(input int ch, output int n);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (run_m[ch]) break;
        end
        cmp("running_rise", ch, 64'(run_m[ch]), 64'(1));
    endtask

    initial begin
        int n, r;
        int last_tog [N];
        int clr_hold [N];

        rst = 1'b1; clear = '0; start = '0; stop = '0; lap = '0;
        repeat (3) @(negedge clk);
        cmp("reset_elapsed", 0, 64'(el_m), 64'(0));
        cmp("reset_lap_time", 0, 64'(lt_m), 64'(0));
        cmp("reset_running", 0, 64'(run_m), 64'(0));
        cmp("reset_overflow", 0, 64'(ov_m), 64'(0));
        cmp("reset_lap_valid", 0, 64'(lv_m), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic run on channel 0.
        toggle(0);
        wait_run(0, n);
        cmp("start_latency", 0, 64'(n), 64'(3));
        repeat (55) @(negedge clk);
        cmp("basic_elapsed", 0, 64'(el_m[0 +: W]), 64'(5));
        cmp("basic_running", 0, 64'(run_m[0]), 64'(1));
        cmp("basic_others", 1, 64'(el_m[N*W-1:W]), 64'(0));

        // Stop / resume on channel 2 with a random prescaler remainder.
        r = $urandom_range(0, 9);
        toggle(2);
        wait_run(2, n);
        repeat (30 + r) @(negedge clk);
        stop[2] = 1'b1;
        @(negedge clk);
        stop[2] = 1'b0;
        cmp("stop_running", 2, 64'(run_m[2]), 64'(0));
        repeat (50) @(negedge clk);
        cmp("hold_elapsed", 2, 64'(el_m[2*W +: W]), 64'(3));
        toggle(2);
        wait_run(2, n);
        n = 0;
        while (el_m[2*W +: W] != 8'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        cmp("resume_latency", 2, 64'(n), 64'(10 - r));

        // Lap landing on the 7 -> 8 tick of channel 3.
        toggle(3);
        wait_run(3, n);
        repeat (79) @(negedge clk);
        lap[3] = 1'b1;
        @(negedge clk);
        lap[3] = 1'b0;
        cmp("lap_tick_valid", 3, 64'(lv_m[3]), 64'(1));
        cmp("lap_tick_time", 3, 64'(lt_m[3*W +: W]), 64'(7));
        cmp("lap_tick_elapsed", 3, 64'(el_m[3*W +: W]), 64'(8));
        @(negedge clk);
        cmp("lap_valid_once", 3, 64'(lv_m[3]), 64'(0));

        // Clear discards start on channel 1, then saturate / wrap on the 4-bit views.
        clear[1] = 1'b1;
        @(negedge clk);
        toggle(1);
        repeat (6) @(negedge clk);
        cmp("clear_running", 1, 64'(run_m[1]), 64'(0));
        cmp("clear_elapsed", 1, 64'(el_m[W +: W]), 64'(0));
        clear[1] = 1'b0;
        @(negedge clk);
        toggle(1);
        wait_run(1, n);
        cmp("clear_restart_latency", 1, 64'(n), 64'(3));
        repeat (160) @(negedge clk);
        cmp("sat_elapsed", 1, 64'(el_s[SW +: SW]), 64'(15));
        cmp("sat_overflow", 1, 64'(ov_s[1]), 64'(1));
        cmp("wrap_elapsed", 1, 64'(el_w[SW +: SW]), 64'(0));
        cmp("wrap_overflow", 1, 64'(ov_w[1]), 64'(1));
        cmp("wide_elapsed", 1, 64'(el_m[W +: W]), 64'(16));

        // Reset mid-run with every channel at 6.
        clear = '1;
        repeat (2) @(negedge clk);
        clear = '0;
        @(negedge clk);
        start = ~start;
        wait_run(0, n);
        repeat (60) @(negedge clk);
        for (int i = 0; i < N; i++) cmp("pre_reset_elapsed", i, 64'(el_m[i*W +: W]), 64'(6));
        rst = 1'b1;
        start = '0;
        @(negedge clk);
        rst = 1'b0;
        cmp("rst_elapsed", 0, 64'(el_m), 64'(0));
        cmp("rst_lap_time", 0, 64'(lt_m), 64'(0));
        cmp("rst_running", 0, 64'(run_m), 64'(0));
        cmp("rst_overflow", 0, 64'(ov_m | {2'b00, ov_s} | {2'b00, ov_w}), 64'(0));
        repeat (20) @(negedge clk);
        cmp("rst_stays_idle", 0, 64'(run_m), 64'(0));

        // Randomised traffic on all channels.
        for (int i = 0; i < N; i++) begin
            last_tog[i] = -10;
            clr_hold[i] = 0;
        end
        for (int k = 0; k < 3000; k++) begin
            stop = '0; lap = '0; rst = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (clr_hold[i] > 0) begin
                    clr_hold[i]--;
                    if (clr_hold[i] == 0) clear[i] = 1'b0;
                end else if ($urandom_range(0, 199) == 0) begin
                    clear[i] = 1'b1;
                    clr_hold[i] = $urandom_range(1, 4);
                end
                if ($urandom_range(0, 39) == 0 && (k - last_tog[i]) >= 3) begin
                    toggle(i);
                    last_tog[i] = k;
                end
                if ($urandom_range(0, 59) == 0) stop[i] = 1'b1;
                if ($urandom_range(0, 24) == 0) lap[i] = 1'b1;
            end
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1;
                start = '0;
                for (int i = 0; i < N; i++) last_tog[i] = k;
            end
            @(negedge clk);
        end
        stop = '0; lap = '0; rst = 1'b0; clear = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) cmp("lap_queue_drained", i, 64'(lapq[i].size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/zcu_multi_timer.md
# zcu_multi_timer

Multi-channel millisecond stopwatch for the ZCU prop controller. It replaces the single-channel elapsed-time counter with N independent channels. Each channel has a parametrised tick rate and width, start/resume, stop/hold, lap capture and overflow handling. It sits beside the DTMF/prop sequencing logic, which reads per-channel elapsed times to schedule effects.

## Interface
- `CLK_HZ`, default 100_000_000: `clk` frequency.
- `TICK_HZ`, default 1000: counting rate. `PRE_MAX = CLK_HZ/TICK_HZ - 1`; `CLK_HZ` must be an exact multiple of `TICK_HZ`.
- `N_CH`, default 4: number of channels, 1..16.
- `WIDTH`, default 24: elapsed-counter width.
- `SATURATE`, default 1: 1 = hold at all-ones on overflow; 0 = wrap to 0.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `clear`  in  N_CH  level, `clk` domain. Forces the channel to IDLE with all counts zero.
- `start`  in  N_CH  asynchronous toggle. Each edge, rising or falling, is one start request.
- `stop`  in  N_CH  single-cycle pulse, `clk` domain.
- `lap`  in  N_CH  single-cycle pulse, `clk` domain.
- `elapsed`  out  N_CH*WIDTH  tick count. Channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `lap_time`  out  N_CH*WIDTH  last captured elapsed value, same packing.
- `lap_valid`  out  N_CH  one-cycle strobe when `lap_time` updates.
- `running`  out  N_CH  channel is in RUN.
- `overflow`  out  N_CH  sticky; cleared by `rst`, `clear` or a start from IDLE.

## Operation
Per-channel state machine with states IDLE, RUN and HOLD:
- IDLE + start edge -> RUN. Prescaler, `elapsed` and `overflow` are zeroed.
- RUN + `stop` -> HOLD. Prescaler and `elapsed` freeze; no increment in that cycle.
- HOLD + start edge -> RUN. Resumes from the frozen prescaler and `elapsed` values; nothing is zeroed.
- RUN + start edge: ignored. The edge is consumed.
- `clear` has priority over every other input and forces IDLE with zeroed counts. Start edges arriving while `clear` is high are discarded.

Priority within a channel: `rst` > `clear` > `stop` > start edge > tick.

Counting in RUN:
- The prescaler counts 0..`PRE_MAX`.
- At `PRE_MAX` the prescaler returns to 0 and `elapsed` increments.

Overflow, when an increment occurs with `elapsed` at all-ones:
- `SATURATE=1`: `elapsed` stays at all-ones and `overflow` sets. The prescaler keeps running.
- `SATURATE=0`: `elapsed` wraps to 0 and `overflow` sets.

Lap capture:
- `lap` in RUN or HOLD copies the current registered `elapsed` (the pre-increment value if a tick lands in the same cycle) into `lap_time`.
- `lap_valid` pulses on the next cycle.
- `lap` in IDLE is ignored.

Channels are fully independent; simultaneous events on different channels never interact.

## Timing
- Reset values: `elapsed`=0, `lap_time`=0, `lap_valid`=0, `running`=0, `overflow`=0, all channels IDLE, synchroniser flops 0.
- `start` synchroniser: two flops plus a third flop for edge detection.
  - An edge first sampled at clock edge k is acted on at edge k+2.
  - `running` is high after edge k+2.
  - Minimum spacing between toggles is 3 clocks; closer toggles may merge.
- First increment: `elapsed` becomes 1 at `PRE_MAX+1` clocks after `running` rises (100 000 clocks at the defaults).
- `stop` and `clear` take effect at the clock edge where they are sampled. `running` falls at that same edge.
- `lap_valid` and `lap_time` both update one clock after `lap` is sampled.
- `rst` asserted mid-count restores every reset value at the next clock edge.

## Structure
- Package `zcu_timer_pkg`:
  - `typedef enum logic [1:0] {TMR_IDLE, TMR_RUN, TMR_HOLD} tmr_state_t`.
  - Function `pre_max(clk_hz, tick_hz)`.
  - Prescaler width derived with `$clog2(PRE_MAX+1)`.
- Sub-module `zcu_timer_channel`: one channel, containing the synchroniser, FSM, prescaler, counter, lap register and overflow flag. The top-level `zcu_multi_timer` instantiates it N_CH times in a generate loop and packs the outputs.

## Test plan
- Bench configuration: `CLK_HZ=1000`, `TICK_HZ=100`, so `PRE_MAX`=9.
- Basic run: toggle `start[0]`, run 55 clocks after `running[0]` rises -> `elapsed[0]`=5, `running[0]`=1. Other channels stay 0.
- Stop/resume: run to `elapsed`=3, pulse `stop`, wait 50 clocks -> still 3. Toggle `start` -> 4 appears exactly (10 - prescaler remainder) clocks after resume.
- Saturate/wrap: `WIDTH=4`, run 16 ticks.
  - `SATURATE=1` -> `elapsed`=15, `overflow`=1.
  - `SATURATE=0` -> `elapsed`=0, `overflow`=1.
- Lap on a tick cycle: pulse `lap` in the same cycle as the 7->8 increment -> `lap_time`=7, `lap_valid` high for exactly one cycle, `elapsed`=8.
- Clear versus start: drive `clear[1]` high and toggle `start[1]` -> channel stays IDLE with `elapsed`=0. Release `clear` and toggle again -> `running[1]` high 3 edges later.
- Reset mid-run: assert `rst` for one clock at `elapsed`=6 on all channels -> all outputs 0 on the next clock, and channels stay IDLE until new start edges.
